gate_tt_checker: RTL and testbench

- Hardware responder that closes the loop on 2-input gate truth-table testing.
- It drives the a/b inputs of a gate under test, waits a settle window, samples the gate output and compares it against the selected gate function.
- It sweeps all four 2-valued input rows, counts mismatches and reports pass/fail with a done pulse.
- It replaces hand-written display sequences for buf/nand/xnor drills with a self-checking clocked sequencer.

---
 rtl/gate_tt_checker.sv | 112 +++++++++++
 tb/tb_gate_tt_checker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gate_tt_checker.sv
// Sequences a 2-input gate under test through all four {a,b} rows and checks dut_out against gate_sel's function.
// Latency: row r is sampled (r+1)*(SETTLE_CYCLES+2) cycles after start; done pulses one cycle after the last sample.
// Backpressure: none; start is honoured only when idle. Optional GATE_TT_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module gate_tt_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] gate_sel,
    input  logic       dut_out,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [1:0] fail_row
);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SAMPLE, DONE} state_t;

    localparam int          SETTLE_LAST_I = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [3:0]  SETTLE_LAST   = SETTLE_LAST_I[3:0];

    state_t     state, state_nx;
    logic [1:0] row;
    logic [1:0] sel;
    logic [3:0] settle_cnt;
    logic       exp_val;
    logic       mism;
    logic       sweep_end;

    always_comb begin
        exp_val = 1'b0;
        case (sel)
            2'b00:   exp_val = a;
            2'b01:   exp_val = ~(a & b);
            2'b10:   exp_val = ~(a ^ b);
            default: exp_val = a ^ b;
        endcase
    end

    // Identity compare so an undriven or floating gate output is treated as a failure.
    assign mism = !(dut_out === exp_val);

`ifdef GATE_TT_STOP_ON_FAIL_EN
    assign sweep_end = (row == 2'd3) || mism;
`else
    assign sweep_end = (row == 2'd3);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
            SETTLE:  if (settle_cnt == SETTLE_LAST) state_nx = SAMPLE;
            SAMPLE:  state_nx = sweep_end ? DONE : LOAD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a          <= 1'b0;
            b          <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            fail_row   <= 2'd0;
            row        <= 2'd0;
            sel        <= 2'd0;
            settle_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sel       <= gate_sel;
                    err_count <= 3'd0;
                    fail_row  <= 2'd0;
                    pass      <= 1'b0;
                    row       <= 2'd0;
                end
                LOAD: begin
                    a          <= row[1];
                    b          <= row[0];
                    settle_cnt <= 4'd0;
                end
                SETTLE: settle_cnt <= settle_cnt + 4'd1;
                SAMPLE: begin
                    if (mism) begin
                        err_count <= err_count + 3'd1;
                        if (err_count == 3'd0) fail_row <= row;
                    end
                    // pass reflects the count including this final sample
                    if (sweep_end) pass <= (err_count == 3'd0) && !mism;
                    else           row  <= row + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_gate_tt_checker.sv
// Drives two checkers (settle 0 and settle 2) with modelled gates under test and scores every sweep.
module tb_gate_tt_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st    [2];
    logic [1:0] gsel  [2];
    logic [3:0] resp  [2];
    logic       dout  [2];
    logic       a_o   [2];
    logic       b_o   [2];
    logic       busy  [2];
    logic       done  [2];
    logic       pass  [2];
    logic [2:0] errc  [2];
    logic [1:0] frow  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // gate under test: each row's response is a table entry, may be x
    always_comb begin
        dout[0] = resp[0][{a_o[0], b_o[0]}];
        dout[1] = resp[1][{a_o[1], b_o[1]}];
    end

    gate_tt_checker #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .gate_sel(gsel[0]), .dut_out(dout[0]),
        .a(a_o[0]), .b(b_o[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .err_count(errc[0]), .fail_row(frow[0])
    );

    gate_tt_checker #(.SETTLE_CYCLES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .gate_sel(gsel[1]), .dut_out(dout[1]),
        .a(a_o[1]), .b(b_o[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .err_count(errc[1]), .fail_row(frow[1])
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic gate_fn(input logic [1:0] s, input int r);
        int x = r / 2;
        int y = r % 2;
        case (s)
            2'd0:    return logic'(x);
            2'd1:    return logic'(1 - x * y);
            2'd2:    return logic'(x == y);
            default: return logic'(x != y);
        endcase
    endfunction

    function automatic logic [3:0] ideal(input logic [1:0] s);
        logic [3:0] t;
        for (int r = 0; r < 4; r++) t[r] = gate_fn(s, r);
        return t;
    endfunction

    task automatic run_sweep(input int k, input logic [1:0] gs, input logic [3:0] rv, input bit restart);
        int per   = (k == 0) ? 2 : 4;
        int errs  = 0;
        int first = -1;
        int last  = 3;
        int expd;
        int ndone = 0;
        for (int r = 0; r < 4; r++) begin
            if (rv[r] !== gate_fn(gs, r)) begin
                errs++;
                if (first < 0) first = r;
            end
        end
`ifdef GATE_TT_STOP_ON_FAIL_EN
        if (first >= 0) begin
            errs = 1;
            last = first;
        end
`endif
        expd = (last + 1) * per;

        @(negedge clk);
        resp[k] = rv;
        gsel[k] = gs;
        st[k]   = 1'b1;
        @(posedge clk);
        for (int n = 0; n <= expd + 3; n++) begin
            @(negedge clk);
            if (n == 0) begin
                st[k] = 1'b0;
                chk_val("busy_after_start", busy[k], 1);
            end
            if (n == 1) gsel[k] = ~gs;
            if (restart && n == 2) st[k] = 1'b1;
            if (restart && n == 3) st[k] = 1'b0;
            for (int r = 0; r <= last; r++)
                if (n == r * per + 1) chk_val("ab_row", {a_o[k], b_o[k]}, r);
            if (done[k] === 1'b1) ndone++;
            if (n == expd) begin
                chk_val("done_time", done[k], 1);
                chk_val("busy_in_done", busy[k], 1);
                chk_val("pass", pass[k], (errs == 0));
                chk_val("err_count", errc[k], errs);
                chk_val("fail_row", frow[k], (first < 0) ? 0 : first);
            end
            if (n == expd + 1) chk_val("busy_end", busy[k], 0);
        end
        chk_val("done_count", ndone, 1);
        chk_val("ab_hold", {a_o[k], b_o[k]}, last);
        chk_val("pass_hold", pass[k], (errs == 0));
    endtask

    initial begin
        logic [3:0] rv;
        logic [1:0] gs;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            st[k] = 1'b0; gsel[k] = 2'd0; resp[k] = 4'd0;
        end
        repeat (3) @(negedge clk);
        chk_val("rst_ab", {a_o[1], b_o[1]}, 0);
        chk_val("rst_busy_done", {busy[1], done[1], busy[0], done[0]}, 0);
        chk_val("rst_pass_err_row", {pass[1], errc[1], frow[1]}, 0);
        rst_n = 1'b1;

        run_sweep(1, 2'b01, ideal(2'b01), 1'b0);
        run_sweep(1, 2'b10, ideal(2'b01), 1'b0);
        run_sweep(1, 2'b00, 4'b0000, 1'b0);
        run_sweep(0, 2'b11, ideal(2'b11), 1'b1);
        rv = ideal(2'b01);
        rv[0] = 1'bx;
        run_sweep(1, 2'b01, rv, 1'b0);

        // reset in the middle of a failing sweep
        @(negedge clk);
        resp[1] = 4'b0000;
        gsel[1] = 2'b01;
        st[1]   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[1] = 1'b0;
        repeat (6) @(negedge clk);
        chk_val("pre_reset_err", errc[1], 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_val("arst_ab", {a_o[1], b_o[1]}, 0);
        chk_val("arst_flags", {busy[1], done[1], pass[1]}, 0);
        chk_val("arst_err_row", {errc[1], frow[1]}, 0);
        repeat (3) begin
            @(negedge clk);
            chk_val("no_done_in_reset", done[1], 0);
        end
        rst_n = 1'b1;
        run_sweep(1, 2'b01, ideal(2'b01), 1'b0);

        for (int i = 0; i < 16; i++) begin
            gs = 2'($urandom_range(0, 3));
            rv = ideal(gs);
            for (int r = 0; r < 4; r++) begin
                case ($urandom_range(0, 5))
                    0:       rv[r] = ~rv[r];
                    1:       rv[r] = 1'bx;
                    default: ;
                endcase
            end
            run_sweep(int'($urandom_range(0, 1)), gs, rv, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
